// File: rtl/fp_mul_seq_ctrl.sv
// fp_mul_seq_ctrl: sequential single-precision multiplier controller.
// Accepts operands over valid/ready, runs a shift-and-add mantissa loop of
// MAN_W+1 iterations, normalises and packs the product (truncating), and
// holds the result on a valid/ready output until it is taken.
module fp_mul_seq_ctrl #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int BIAS  = 127
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [EXP_W+MAN_W:0] a,
    input  logic [EXP_W+MAN_W:0] b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [EXP_W+MAN_W:0] p,
    output logic                 overflow,
    output logic                 underflow,
    output logic                 invalid,
    output logic                 busy
);

    localparam int M  = MAN_W + 1;           // hidden-bit mantissa width
    localparam int EW = EXP_W + 2;           // signed working exponent width
    localparam int CW = $clog2(MAN_W + 2);   // iteration counter width
    localparam int TOP = EXP_W + MAN_W;      // sign bit index

    localparam logic signed [EW-1:0] EMAX = EW'((2 ** EXP_W) - 1);
    localparam logic [TOP:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_NORM = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t r_state;
    state_t w_next;

    // Operand unpack (combinational on the input port, used on accept)
    logic [EXP_W-1:0] w_ea, w_eb;
    logic [MAN_W-1:0] w_fa, w_fb;
    logic             w_a_zero, w_a_inf, w_a_nan;
    logic             w_b_zero, w_b_inf, w_b_nan;
    logic             w_nan_res, w_inf_res, w_zero_res, w_special;

    assign w_ea = a[TOP-1:MAN_W];
    assign w_eb = b[TOP-1:MAN_W];
    assign w_fa = a[MAN_W-1:0];
    assign w_fb = b[MAN_W-1:0];

    // Exponent 0 is zero (denormals flush); all-ones is inf or NaN by fraction.
    assign w_a_zero = (w_ea == '0);
    assign w_b_zero = (w_eb == '0);
    assign w_a_inf  = (&w_ea) & ~(|w_fa);
    assign w_b_inf  = (&w_eb) & ~(|w_fb);
    assign w_a_nan  = (&w_ea) &  (|w_fa);
    assign w_b_nan  = (&w_eb) &  (|w_fb);

    assign w_nan_res  = w_a_nan | w_b_nan | (w_a_inf & w_b_zero) | (w_b_inf & w_a_zero);
    assign w_inf_res  = ~w_nan_res & (w_a_inf | w_b_inf);
    assign w_zero_res = ~w_nan_res & ~w_inf_res & (w_a_zero | w_b_zero);
    assign w_special  = w_nan_res | w_inf_res | w_zero_res;

    // Working registers
    logic                 r_sign;
    logic signed [EW-1:0] r_exp;
    logic [M-1:0]         r_mcand;
    logic [M-1:0]         r_mplr;
    logic [2*M-1:0]       r_acc;
    logic [CW-1:0]        r_cnt;
    logic                 r_sp_nan, r_sp_inf, r_sp_zero;
    logic [TOP:0]         r_p;
    logic                 r_ovf, r_unf, r_inv;

    // One shift-and-add step: add into the upper half keeping the carry,
    // then the carry re-enters at the top as {carry, acc} shifts right.
    logic [M:0] w_sum;
    assign w_sum = {1'b0, r_acc[2*M-1:M]} + (r_mplr[0] ? {1'b0, r_mcand} : {(M+1){1'b0}});

    // Normalisation: a product in [2,4) has its leading one at the top bit.
    logic signed [EW-1:0] w_e_norm;
    logic [MAN_W-1:0]     w_frac;
    logic                 w_ovf, w_unf;

    assign w_e_norm = r_acc[2*M-1] ? (r_exp + EW'(1)) : r_exp;
    assign w_frac   = r_acc[2*M-1] ? r_acc[2*M-2:M] : r_acc[2*M-3:M-1];
    assign w_ovf    = ~w_e_norm[EW-1] & (w_e_norm >= EMAX);
    assign w_unf    = w_e_norm[EW-1] | (w_e_norm == '0);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (in_valid) w_next = w_special ? S_NORM : S_MUL;
            S_MUL:  if (r_cnt == CW'(MAN_W)) w_next = S_NORM;
            S_NORM: w_next = S_DONE;
            S_DONE: if (out_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Handshake and status outputs decoded from state
    always_comb begin
        in_ready  = (r_state == S_IDLE);
        busy      = (r_state != S_IDLE);
        out_valid = (r_state == S_DONE);
    end

    // Datapath: operand latch, multiply loop, pack, flag hold/clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sign    <= 1'b0;
            r_exp     <= '0;
            r_mcand   <= '0;
            r_mplr    <= '0;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_sp_nan  <= 1'b0;
            r_sp_inf  <= 1'b0;
            r_sp_zero <= 1'b0;
            r_p       <= '0;
            r_ovf     <= 1'b0;
            r_unf     <= 1'b0;
            r_inv     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_sign    <= a[TOP] ^ b[TOP];
                        r_exp     <= EW'(w_ea) + EW'(w_eb) - EW'(BIAS);
                        r_mcand   <= {1'b1, w_fa};
                        r_mplr    <= {1'b1, w_fb};
                        r_acc     <= '0;
                        r_cnt     <= '0;
                        r_sp_nan  <= w_nan_res;
                        r_sp_inf  <= w_inf_res;
                        r_sp_zero <= w_zero_res;
                    end
                end
                S_MUL: begin
                    r_acc  <= {w_sum, r_acc[M-1:1]};
                    r_mplr <= r_mplr >> 1;
                    r_cnt  <= r_cnt + CW'(1);
                end
                S_NORM: begin
                    if (r_sp_nan) begin
                        r_p   <= QNAN;
                        r_inv <= 1'b1;
                    end else if (r_sp_inf) begin
                        r_p <= {r_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                    end else if (r_sp_zero) begin
                        r_p <= {r_sign, {(EXP_W+MAN_W){1'b0}}};
                    end else if (w_ovf) begin
                        r_p   <= {r_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                        r_ovf <= 1'b1;
                    end else if (w_unf) begin
                        r_p   <= {r_sign, {(EXP_W+MAN_W){1'b0}}};
                        r_unf <= 1'b1;
                    end else begin
                        r_p <= {r_sign, w_e_norm[EXP_W-1:0], w_frac};
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_ovf <= 1'b0;
                        r_unf <= 1'b0;
                        r_inv <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign p         = r_p;
    assign overflow  = r_ovf;
    assign underflow = r_unf;
    assign invalid   = r_inv;

endmodule

// File: tb/tb_fp_mul_seq_ctrl.sv
// Testbench for fp_mul_seq_ctrl. Cycle E0+k is the cycle following edge
// E0+k-1, where E0 is the accepting edge; outputs are sampled on negedges.
module tb_fp_mul_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] a = 32'h0;
    logic [31:0] b = 32'h0;
    logic        in_ready, out_valid, overflow, underflow, invalid, busy;
    logic [31:0] p;

    int n_chk = 0;
    int n_err = 0;

    fp_mul_seq_ctrl #(.EXP_W(8), .MAN_W(23), .BIAS(127)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .p(p),
        .overflow(overflow), .underflow(underflow), .invalid(invalid), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: IEEE single-precision multiply with flush-to-zero and truncation.
    function automatic void model(input logic [31:0] x, input logic [31:0] y,
                                  output logic [31:0] rp, output logic [2:0] rf, output int rl);
        int          ex, ey, e;
        logic [22:0] fx, fy, frac;
        logic        s, zx, zy, ix, iy, nx, ny;
        logic [47:0] pm;
        ex = int'(x[30:23]); ey = int'(y[30:23]);
        fx = x[22:0];        fy = y[22:0];
        s  = x[31] ^ y[31];
        zx = (ex == 0);   zy = (ey == 0);
        ix = (ex == 255) && (fx == 0); iy = (ey == 255) && (fy == 0);
        nx = (ex == 255) && (fx != 0); ny = (ey == 255) && (fy != 0);
        rf = 3'b000;
        rl = 2;
        if (nx || ny || (ix && zy) || (iy && zx)) begin
            rp = 32'h7FC00000; rf = 3'b001;
        end else if (ix || iy) begin
            rp = {s, 8'hFF, 23'h0};
        end else if (zx || zy) begin
            rp = {s, 31'h0};
        end else begin
            rl = 26;
            pm = 48'({1'b1, fx}) * 48'({1'b1, fy});
            e  = ex + ey - 127;
            if (pm[47]) begin frac = pm[46:24]; e = e + 1; end
            else        frac = pm[45:23];
            if (e >= 255)    begin rp = {s, 8'hFF, 23'h0}; rf = 3'b100; end
            else if (e <= 0) begin rp = {s, 31'h0};        rf = 3'b010; end
            else             rp = {s, e[7:0], frac};
        end
    endfunction

    // Drive one transaction with out_ready high and collect what the DUT shows.
    task automatic run_op(input logic [31:0] ia, input logic [31:0] ib,
                          output int lat, output logic [31:0] op, output logic [2:0] ofl,
                          output logic busy_ok, output logic v_after, output logic r_after);
        out_ready = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 50 && !in_ready; i++) @(negedge clk);
        a = ia; b = ib; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 0; busy_ok = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            busy_ok = busy_ok & busy;
            if (out_valid) begin lat = k; break; end
        end
        op  = p;
        ofl = {overflow, underflow, invalid};
        @(negedge clk);
        v_after = out_valid;
        r_after = in_ready;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        #1;
        n_chk++; if (p !== 32'h0) begin n_err++; $display("FAIL reset_p: got %h want 00000000", p); end
        n_chk++; if ({out_valid, overflow, underflow, invalid, busy} !== 5'b0) begin
            n_err++; $display("FAIL reset_outs: got %b want 00000", {out_valid, overflow, underflow, invalid, busy}); end
        n_chk++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic;
        int lat; logic [31:0] op; logic [2:0] fl; logic bok, va, ra;
        run_op(32'h40400000, 32'h40000000, lat, op, fl, bok, va, ra);
        n_chk++; if (lat !== 26) begin n_err++; $display("FAIL basic_latency: got %0d want 26", lat); end
        n_chk++; if (op !== 32'h40C00000) begin n_err++; $display("FAIL basic_p: got %h want 40c00000", op); end
        n_chk++; if (fl !== 3'b000) begin n_err++; $display("FAIL basic_flags: got %b want 000", fl); end
        n_chk++; if (bok !== 1'b1) begin n_err++; $display("FAIL basic_busy: busy dropped during E0+1..E0+26"); end
        n_chk++; if (va !== 1'b0) begin n_err++; $display("FAIL basic_one_cycle: out_valid got %b want 0", va); end
        n_chk++; if (ra !== 1'b1) begin n_err++; $display("FAIL basic_ready_after: got %b want 1", ra); end
    endtask

    task automatic test_norm;
        int lat; logic [31:0] op; logic [2:0] fl; logic bok, va, ra;
        run_op(32'h3FC00000, 32'h3FC00000, lat, op, fl, bok, va, ra);
        n_chk++; if (op !== 32'h40100000) begin n_err++; $display("FAIL norm_p: got %h want 40100000", op); end
        n_chk++; if (lat !== 26) begin n_err++; $display("FAIL norm_latency: got %0d want 26", lat); end
    endtask

    task automatic test_special;
        int lat; logic [31:0] op; logic [2:0] fl; logic bok, va, ra;
        run_op(32'h7F800000, 32'h00000000, lat, op, fl, bok, va, ra);
        n_chk++; if (op !== 32'h7FC00000) begin n_err++; $display("FAIL inf0_p: got %h want 7fc00000", op); end
        n_chk++; if (fl !== 3'b001) begin n_err++; $display("FAIL inf0_flags: got %b want 001", fl); end
        n_chk++; if (lat !== 2) begin n_err++; $display("FAIL inf0_latency: got %0d want 2", lat); end
        run_op(32'hFF800000, 32'h40000000, lat, op, fl, bok, va, ra);
        n_chk++; if (op !== 32'hFF800000) begin n_err++; $display("FAIL ninf_p: got %h want ff800000", op); end
        n_chk++; if (fl !== 3'b000) begin n_err++; $display("FAIL ninf_flags: got %b want 000", fl); end
        n_chk++; if (lat !== 2) begin n_err++; $display("FAIL ninf_latency: got %0d want 2", lat); end
    endtask

    task automatic test_ovf_unf;
        int lat; logic [31:0] op; logic [2:0] fl; logic bok, va, ra;
        run_op(32'h7F000000, 32'h7F000000, lat, op, fl, bok, va, ra);
        n_chk++; if (op !== 32'h7F800000) begin n_err++; $display("FAIL ovf_p: got %h want 7f800000", op); end
        n_chk++; if (fl !== 3'b100) begin n_err++; $display("FAIL ovf_flags: got %b want 100", fl); end
        run_op(32'h00800000, 32'h00800000, lat, op, fl, bok, va, ra);
        n_chk++; if (op !== 32'h00000000) begin n_err++; $display("FAIL unf_p: got %h want 00000000", op); end
        n_chk++; if (fl !== 3'b010) begin n_err++; $display("FAIL unf_flags: got %b want 010", fl); end
    endtask

    task automatic test_backpressure;
        logic seen;
        int   lat;
        out_ready = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 50 && !in_ready; i++) @(negedge clk);
        a = 32'h3FC00000; b = 32'h3FC00000; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        seen = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (out_valid) begin seen = 1'b1; break; end
        end
        n_chk++; if (seen !== 1'b1) begin n_err++; $display("FAIL bp_valid: out_valid never rose"); end
        // A different operand pair is offered while the result is held.
        for (int i = 0; i < 5; i++) begin
            a = 32'h40400000; b = 32'h40000000; in_valid = 1'b1;
            @(negedge clk);
            n_chk++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL bp_hold_valid[%0d]: got %b want 1", i, out_valid); end
            n_chk++; if (p !== 32'h40100000) begin n_err++; $display("FAIL bp_hold_p[%0d]: got %h want 40100000", i, p); end
            n_chk++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready[%0d]: got %b want 0", i, in_ready); end
        end
        // in_valid and out_ready together in DONE: only the output handshake.
        out_ready = 1'b1;
        @(negedge clk);
        n_chk++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_release_valid: got %b want 0", out_valid); end
        n_chk++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_release_ready: got %b want 1", in_ready); end
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (out_valid) begin lat = k; break; end
        end
        n_chk++; if (lat !== 26) begin n_err++; $display("FAIL bp_next_latency: got %0d want 26", lat); end
        n_chk++; if (p !== 32'h40C00000) begin n_err++; $display("FAIL bp_next_p: got %h want 40c00000", p); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        int lat; logic [31:0] op; logic [2:0] fl; logic bok, va, ra;
        out_ready = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 50 && !in_ready; i++) @(negedge clk);
        a = 32'h40400000; b = 32'h40000000; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        n_chk++; if (busy !== 1'b1) begin n_err++; $display("FAIL rmid_busy_before: got %b want 1", busy); end
        rst = 1'b1;
        #1;
        n_chk++; if (p !== 32'h0) begin n_err++; $display("FAIL rmid_p: got %h want 00000000", p); end
        n_chk++; if ({out_valid, overflow, underflow, invalid, busy} !== 5'b0) begin
            n_err++; $display("FAIL rmid_outs: got %b want 00000", {out_valid, overflow, underflow, invalid, busy}); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_chk++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rmid_in_ready: got %b want 1", in_ready); end
        run_op(32'h40400000, 32'h40000000, lat, op, fl, bok, va, ra);
        n_chk++; if (lat !== 26) begin n_err++; $display("FAIL rmid_latency: got %0d want 26", lat); end
        n_chk++; if (op !== 32'h40C00000) begin n_err++; $display("FAIL rmid_p_after: got %h want 40c00000", op); end
    endtask

    function automatic logic [31:0] rnd_operand();
        int          c;
        logic [7:0]  e;
        logic [22:0] f;
        c = int'($urandom_range(0, 9));
        f = 23'($urandom);
        if (c == 0)      e = 8'h00;
        else if (c == 1) begin e = 8'hFF; if ($urandom_range(0, 1) == 1) f = 23'h0; end
        else if (c == 2) e = 8'($urandom_range(200, 254));
        else if (c == 3) e = 8'($urandom_range(1, 40));
        else             e = 8'($urandom_range(1, 254));
        return {1'($urandom_range(0, 1)), e, f};
    endfunction

    task automatic test_random;
        int lat, rl; logic [31:0] op, rp, x, y; logic [2:0] fl, rf; logic bok, va, ra;
        for (int n = 0; n < 40; n++) begin
            x = rnd_operand();
            y = rnd_operand();
            model(x, y, rp, rf, rl);
            run_op(x, y, lat, op, fl, bok, va, ra);
            n_chk++; if (op !== rp) begin n_err++; $display("FAIL rnd_p[%0d] %h*%h: got %h want %h", n, x, y, op, rp); end
            n_chk++; if (fl !== rf) begin n_err++; $display("FAIL rnd_flags[%0d] %h*%h: got %b want %b", n, x, y, fl, rf); end
            n_chk++; if (lat !== rl) begin n_err++; $display("FAIL rnd_latency[%0d] %h*%h: got %0d want %0d", n, x, y, lat, rl); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_norm();
        test_special();
        test_ovf_unf();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
